// File: rtl/spi_receive.sv
// SPI mode-3 byte receiver: synchronises the pins, deserialises MSB-first bytes
// into a small FWFT FIFO and flags frame ends, partial-byte frames and overrun.
module spi_receive #(
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        sclk,
  input  logic                        cs,
  input  logic                        sdi,
  input  logic                        rd_en,
  input  logic                        ovr_clr,
  output logic [7:0]                  rd_data,
  output logic                        rd_valid,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic [7:0]                  byte_count,
  output logic                        busy,
  output logic                        frame_done,
  output logic                        frame_err,
  output logic                        overrun
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(SYNC_STAGES + 1);

  typedef enum logic [1:0] {WAIT_IDLE, IDLE, RECV} state_t;
  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, sdi_sync;
  logic                   s_sclk, s_cs, s_sdi, p_sclk;
  logic [SW-1:0]          settle_cnt;
  logic                   settled;
  logic [2:0]             bit_cnt;
  logic [6:0]             shift;
  logic                   enter_recv, shift_en, push_req, push_ok, pop, full;
  logic [7:0]             push_byte;
  logic [7:0]             mem [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr, rd_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync <= '1;
      cs_sync   <= '1;
      sdi_sync  <= '1;
      p_sclk    <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
      sdi_sync  <= {sdi_sync[SYNC_STAGES-2:0], sdi};
      p_sclk    <= s_sclk;
    end
  end

  assign s_sclk = sclk_sync[SYNC_STAGES-1];
  assign s_cs   = cs_sync[SYNC_STAGES-1];
  assign s_sdi  = sdi_sync[SYNC_STAGES-1];

  // The chains reset to idle, so s_cs only reflects the pin once they have refilled.
  always_ff @(posedge clk) begin
    if (rst)
      settle_cnt <= '0;
    else if (!settled)
      settle_cnt <= settle_cnt + SW'(1);
  end

  assign settled = (settle_cnt == SW'(SYNC_STAGES));

  always_ff @(posedge clk) begin
    if (rst)
      state <= WAIT_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      WAIT_IDLE: if (settled && s_cs) state_nxt = IDLE;
      IDLE:      if (!s_cs) state_nxt = RECV;
      RECV:      if (s_cs) state_nxt = IDLE;
      default:   state_nxt = WAIT_IDLE;
    endcase
  end

  always_comb begin
    busy       = (state == RECV);
    frame_done = (state == RECV) && s_cs;
    frame_err  = (state == RECV) && s_cs && (bit_cnt != 3'd0);
  end

  // A cs rise wins over a coincident sclk rise because shift_en requires s_cs low.
  assign enter_recv = (state == IDLE) && !s_cs;
  assign shift_en   = (state == RECV) && !s_cs && s_sclk && !p_sclk;
  assign push_req   = shift_en && (bit_cnt == 3'd7);
  assign push_byte  = {shift, s_sdi};

  always_ff @(posedge clk) begin
    if (rst || enter_recv) begin
      bit_cnt    <= '0;
      shift      <= '0;
      byte_count <= '0;
    end else if (shift_en) begin
      shift   <= {shift[5:0], s_sdi};
      bit_cnt <= bit_cnt + 3'd1;
      if (bit_cnt == 3'd7 && byte_count != 8'hFF)
        byte_count <= byte_count + 8'd1;
    end
  end

  assign full     = (fifo_count == CW'(FIFO_DEPTH));
  assign rd_valid = (fifo_count != '0);
  assign pop      = rd_en && rd_valid;
  assign push_ok  = push_req && (!full || pop);
  assign rd_data  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok)
      mem[wr_ptr] <= push_byte;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push_ok)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      overrun <= 1'b0;
    else if (push_req && full && !pop)
      overrun <= 1'b1;
    else if (ovr_clr)
      overrun <= 1'b0;
  end

endmodule

// File: tb/tb_spi_receive.sv
// Randomised bench for spi_receive: drives SPI frames on the pins and compares
// the FIFO contents and status against a queue-based model of the receiver.
module tb_spi_receive;

  localparam int FIFO_DEPTH  = 4;
  localparam int SYNC_STAGES = 2;

  logic       clk = 1'b0, rst = 1'b1, sclk = 1'b1, cs = 1'b1, sdi = 1'b0;
  logic       rd_en = 1'b0, ovr_clr = 1'b0;
  logic [7:0] rd_data, byte_count;
  logic       rd_valid, busy, frame_done, frame_err, overrun;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;

  spi_receive #(.FIFO_DEPTH(FIFO_DEPTH), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .cs(cs), .sdi(sdi),
    .rd_en(rd_en), .ovr_clr(ovr_clr), .rd_data(rd_data), .rd_valid(rd_valid),
    .fifo_count(fifo_count), .byte_count(byte_count), .busy(busy),
    .frame_done(frame_done), .frame_err(frame_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int         checks = 0, failures = 0;
  int         doneCount = 0, errCount = 0, errAlone = 0;
  logic [7:0] modelQ[$];
  logic       modelOvr = 1'b0;

  always @(negedge clk) begin
    if (frame_done) doneCount++;
    if (frame_err) errCount++;
    if (frame_err && !frame_done) errAlone++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic modelPush(input logic [7:0] b);
    if (modelQ.size() < FIFO_DEPTH) modelQ.push_back(b);
    else modelOvr = 1'b1;
  endtask

  task automatic sendBit(input logic b, input int half);
    sclk = 1'b0; sdi = b; tick(half);
    sclk = 1'b1; tick(half);
  endtask

  // Sends one byte MSB first and books it in the model.
  task automatic applyStimulus(input logic [7:0] data, input int half);
    for (int i = 7; i >= 0; i--) sendBit(data[i], half);
    modelPush(data);
  endtask

  task automatic sendTimed(input logic [7:0] data, input string tag);
    logic [$clog2(FIFO_DEPTH):0] prev;
    int lat;
    for (int i = 7; i >= 1; i--) sendBit(data[i], 2);
    sclk = 1'b0; sdi = data[0]; tick(2);
    prev = fifo_count;
    sclk = 1'b1;
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      tick(1);
      lat = k;
      if (fifo_count != prev) break;
    end
    checkOutput(tag, lat, SYNC_STAGES + 1);
    modelPush(data);
  endtask

  task automatic csLow;
    cs = 1'b0; tick(4);
  endtask

  task automatic csHigh(input int expErr, input int expDone);
    int d0, e0;
    d0 = doneCount; e0 = errCount;
    cs = 1'b1;
    for (int k = 0; k < 20 && doneCount == d0; k++) tick(1);
    tick(2);
    @(negedge clk);
    checkOutput("frame_done_pulses", doneCount - d0, expDone);
    checkOutput("frame_err_pulses", errCount - e0, expErr);
    checkOutput("frame_err_alone", errAlone, 0);
    checkOutput("busy_after_frame", busy, 1'b0);
  endtask

  task automatic checkState(input string tag);
    @(negedge clk);
    checkOutput({tag, "_count"}, fifo_count, modelQ.size());
    checkOutput({tag, "_valid"}, rd_valid, modelQ.size() != 0);
    checkOutput({tag, "_overrun"}, overrun, modelOvr);
  endtask

  task automatic popCheck(input string tag);
    logic [7:0] exp;
    @(negedge clk);
    if (modelQ.size() == 0) begin
      checkOutput({tag, "_valid"}, rd_valid, 1'b0);
      return;
    end
    exp = modelQ.pop_front();
    checkOutput({tag, "_valid"}, rd_valid, 1'b1);
    checkOutput({tag, "_data"}, rd_data, exp);
    @(posedge clk); #1 rd_en = 1'b1;
    @(posedge clk); #1 rd_en = 1'b0;
  endtask

  task automatic drain(input string tag);
    while (modelQ.size() > 0) popCheck(tag);
    checkState({tag, "_empty"});
  endtask

  task automatic doReset;
    rst = 1'b1; tick(1); rst = 1'b0;
    modelQ.delete();
    modelOvr = 1'b0;
  endtask

  initial begin
    logic [7:0] head;
    int half, nb, extra, np;

    tick(3);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_valid", rd_valid, 1'b0);
    checkOutput("rst_count", fifo_count, 0);
    checkOutput("rst_byte_count", byte_count, 0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_done", frame_done, 1'b0);
    checkOutput("rst_err", frame_err, 1'b0);
    checkOutput("rst_overrun", overrun, 1'b0);
    tick(6);

    // Two clean bytes in one frame.
    csLow;
    applyStimulus(8'hA5, 4);
    applyStimulus(8'h3C, 4);
    @(negedge clk);
    checkOutput("two_byte_count", fifo_count, 2);
    csHigh(0, 1);
    checkOutput("two_byte_bytes", byte_count, 2);
    drain("two_byte");

    // Partial trailing byte.
    csLow;
    applyStimulus(8'hF0, 3);
    for (int i = 0; i < 5; i++) sendBit(1'($urandom), 3);
    csHigh(1, 1);
    checkOutput("partial_bytes", byte_count, 1);
    drain("partial");

    // Overrun with no reads, then clear.
    csLow;
    for (int i = 1; i <= 5; i++) applyStimulus(8'(i), 2);
    csHigh(0, 1);
    checkOutput("ovr_bytes", byte_count, 5);
    checkState("ovr_full");
    drain("ovr");
    ovr_clr = 1'b1; tick(1); ovr_clr = 1'b0;
    modelOvr = 1'b0;
    checkState("ovr_clr");

    // Full FIFO with a pop exactly in the push cycle of the fifth byte.
    csLow;
    for (int i = 1; i <= 4; i++) applyStimulus(8'(i), 2);
    for (int i = 7; i >= 1; i--) sendBit(1'(8'h05 >> i), 2);
    sclk = 1'b0; sdi = 1'b1; tick(2);
    sclk = 1'b1; tick(SYNC_STAGES);
    rd_en = 1'b1;
    @(negedge clk);
    head = modelQ.pop_front();
    checkOutput("pushpop_head", rd_data, head);
    checkOutput("pushpop_full", fifo_count, FIFO_DEPTH);
    @(posedge clk); #1 rd_en = 1'b0;
    modelQ.push_back(8'h05);
    tick(1);
    csHigh(0, 1);
    checkState("pushpop");
    drain("pushpop");

    // Reset in the middle of a frame with cs held low.
    csLow;
    applyStimulus(8'h5A, 2);
    csHigh(0, 1);
    csLow;
    for (int i = 0; i < 3; i++) sendBit(1'b1, 2);
    sclk = 1'b0; sdi = 1'b0; tick(1);
    doReset;
    tick(1);
    sclk = 1'b1; tick(2);
    for (int i = 0; i < 8; i++) sendBit(1'($urandom), 2);
    @(negedge clk);
    checkOutput("midrst_busy", busy, 1'b0);
    checkOutput("midrst_bytes", byte_count, 0);
    checkState("midrst");
    csHigh(0, 0);
    csLow;
    applyStimulus(8'h81, 2);
    csHigh(0, 1);
    checkOutput("midrst_after_bytes", byte_count, 1);
    drain("midrst_after");

    // Minimum sclk high/low time with push latency measured on the 8th rise.
    csLow;
    sendTimed(8'hFF, "latency_ff");
    sendTimed(8'h00, "latency_00");
    csHigh(0, 1);
    drain("timing");

    // Randomised frames with random partial reads between them.
    for (int f = 0; f < 8; f++) begin
      half  = $urandom_range(2, 4);
      nb    = $urandom_range(0, 3);
      extra = $urandom_range(0, 7);
      csLow;
      for (int b = 0; b < nb; b++) applyStimulus(8'($urandom), half);
      for (int e = 0; e < extra; e++) sendBit(1'($urandom), half);
      csHigh(extra != 0, 1);
      checkOutput("rand_bytes", byte_count, nb);
      checkState("rand");
      np = $urandom_range(0, modelQ.size());
      for (int p = 0; p < np; p++) popCheck("rand_pop");
      if (modelOvr && $urandom_range(0, 1) == 1) begin
        ovr_clr = 1'b1; tick(1); ovr_clr = 1'b0;
        modelOvr = 1'b0;
      end
    end
    drain("rand_final");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

endmodule
